// File: rtl/riscv_pkg.sv
// Shared RV64I load/store definitions: funct3 codes, LSU state encoding,
// byte-lane masks and request legality helpers.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [7:0] BE_B = 8'h01;
   localparam logic [7:0] BE_H = 8'h03;
   localparam logic [7:0] BE_W = 8'h0F;
   localparam logic [7:0] BE_D = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   // funct3[1:0] encodes the access size for both signed and unsigned loads
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return BE_B;
         2'b01:   return BE_H;
         2'b10:   return BE_W;
         2'b11:   return BE_D;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      return we ? (f3[2] == 1'b0) : (f3 != 3'b111);
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
      case (sz)
         2'b00:   return 1'b0;
         2'b01:   return off[0] != 1'b0;
         2'b10:   return off[1:0] != 2'b00;
         2'b11:   return off != 3'b000;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load aligner: selects the addressed lanes of a 64-bit beat
// and sign/zero-extends to 64 bits according to funct3.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] data
);

   logic [63:0] shifted_s;

   assign shifted_s = rdata >> {offset, 3'b000};

   // size select and extension
   always_comb begin
      data = 64'h0;
      case (funct3)
         F3_B:    data = {{56{shifted_s[7]}},  shifted_s[7:0]};
         F3_H:    data = {{48{shifted_s[15]}}, shifted_s[15:0]};
         F3_W:    data = {{32{shifted_s[31]}}, shifted_s[31:0]};
         F3_D:    data = shifted_s;
         F3_BU:   data = {56'h0, shifted_s[7:0]};
         F3_HU:   data = {48'h0, shifted_s[15:0]};
         F3_WU:   data = {32'h0, shifted_s[31:0]};
         default: data = 64'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// RV64I load/store unit driving a 64-bit valid/ack data-memory port.
// Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_port
   import riscv_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int MEM_AW      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_be,
   output logic [63:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [63:0]       mem_rdata
);

   lsu_state_e  state_r;
   logic        we_r;
   logic [2:0]  f3_r;
   logic [2:0]  off_r;
   logic [63:0] load_data_s;
   logic        req_err_s;
   logic        timeout_s;
   logic        unused_s;

   assign req_err_s = !f3_legal(req_we, req_funct3) ||
                      misaligned(req_funct3[1:0], req_addr[2:0]);
   assign unused_s  = ^req_addr[XLEN-1:MEM_AW];

   lsu_load_align u_align (
      .rdata  (mem_rdata),
      .offset (off_r),
      .funct3 (f3_r),
      .data   (load_data_s)
   );

`ifdef LSU_TIMEOUT_EN
   logic [15:0] cnt_r;

   assign timeout_s = (cnt_r == 16'(TIMEOUT_CYC - 1));

   // counts un-acked ACCESS cycles; held at zero outside ACCESS
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 16'h0;
      end else if (state_r != ST_ACCESS) begin
         cnt_r <= 16'h0;
      end else if (!mem_ack) begin
         cnt_r <= cnt_r + 16'h1;
      end else begin
         cnt_r <= cnt_r;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // request FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         we_r      <= 1'b0;
         f3_r      <= 3'b000;
         off_r     <= 3'b000;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 8'h00;
         mem_wdata <= 64'h0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  we_r      <= req_we;
                  f3_r      <= req_funct3;
                  off_r     <= req_addr[2:0];
                  req_ready <= 1'b0;
                  if (req_err_s) begin
                     state_r   <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state_r   <= ST_ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[MEM_AW-1:3], 3'b000};
                     mem_be    <= size_mask(req_funct3[1:0]) << req_addr[2:0];
                     mem_wdata <= req_wdata[63:0] << {req_addr[2:0], 3'b000};
                  end
               end
            end
            ST_ACCESS: begin
               // an ack in the watchdog's final cycle still completes normally
               if (mem_ack) begin
                  state_r   <= ST_RESP;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= 8'h00;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= we_r ? '0 : load_data_s;
               end else if (timeout_s) begin
                  state_r   <= ST_RESP;
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= 8'h00;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end
            end
            ST_RESP: begin
               state_r   <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: begin
               state_r   <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               mem_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port; outputs sampled on the
// falling edge, inputs driven just after it.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_be;
   logic [63:0] mem_wdata;
   logic        mem_ack;
   logic [63:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_mem_port #(.XLEN(64), .MEM_AW(32), .TIMEOUT_CYC(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // presents a request for one edge; returns at the falling edge of cycle N+1
   task automatic issue(input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   // acks in the current cycle; returns at the falling edge of the RESP cycle
   task automatic ack_now(input logic [63:0] rdata);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_ack   = 1'b0;
   endtask

   task automatic load_case(input string tag, input logic [2:0] f3,
                            input logic [63:0] addr, input logic [63:0] rdata,
                            input logic [63:0] exp);
      issue(1'b0, f3, addr, 64'h0);
      ack_now(rdata);
      chk({tag, "_valid"}, {63'h0, rsp_valid}, 64'h1);
      chk({tag, "_rdata"}, rsp_rdata, exp);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
      req_addr = 64'h0; req_wdata = 64'h0; mem_ack = 1'b0; mem_rdata = 64'h0;
      #12;
      chk("rst_ready", {63'h0, req_ready}, 64'h1);
      chk("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
      chk("rst_rsp_rdata", rsp_rdata, 64'h0);
      chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
      chk("rst_mem_be", {56'h0, mem_be}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // LB 0x1003, ack on the second ACCESS cycle; extra req_valid ignored
      issue(1'b0, 3'b000, 64'h1003, 64'h0);
      chk("lb_mem_req", {63'h0, mem_req}, 64'h1);
      chk("lb_mem_addr", {32'h0, mem_addr}, 64'h1000);
      chk("lb_mem_be", {56'h0, mem_be}, 64'h08);
      chk("lb_mem_we", {63'h0, mem_we}, 64'h0);
      chk("lb_ready", {63'h0, req_ready}, 64'h0);
      req_valid = 1'b1; req_addr = 64'h9000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("lb_hold_addr", {32'h0, mem_addr}, 64'h1000);
      chk("lb_no_early_rsp", {63'h0, rsp_valid}, 64'h0);
      ack_now(64'h00000000_80FF0000);
      chk("lb_valid", {63'h0, rsp_valid}, 64'h1);
      chk("lb_rdata", rsp_rdata, 64'hFFFFFFFF_FFFFFF80);
      chk("lb_err", {63'h0, rsp_err}, 64'h0);
      chk("lb_mem_req_drop", {63'h0, mem_req}, 64'h0);
      @(negedge clk);
      chk("lb_valid_pulse", {63'h0, rsp_valid}, 64'h0);
      chk("lb_ready_back", {63'h0, req_ready}, 64'h1);

      // SW 0x2004
      issue(1'b1, 3'b010, 64'h2004, 64'h11223344_AABBCCDD);
      chk("sw_mem_be", {56'h0, mem_be}, 64'hF0);
      chk("sw_mem_wdata_hi", {32'h0, mem_wdata[63:32]}, 64'hAABBCCDD);
      chk("sw_mem_we", {63'h0, mem_we}, 64'h1);
      chk("sw_mem_addr", {32'h0, mem_addr}, 64'h2000);
      ack_now(64'hFFFFFFFF_FFFFFFFF);
      chk("sw_valid", {63'h0, rsp_valid}, 64'h1);
      chk("sw_rdata", rsp_rdata, 64'h0);
      chk("sw_err", {63'h0, rsp_err}, 64'h0);
      @(negedge clk);

      // SB lane placement at offset 5
      issue(1'b1, 3'b000, 64'h2005, 64'h00000000_000000A5);
      chk("sb_mem_be", {56'h0, mem_be}, 64'h20);
      chk("sb_mem_wdata", mem_wdata, 64'h0000A500_00000000);
      ack_now(64'h0);
      @(negedge clk);

      load_case("lhu", 3'b101, 64'h3006, 64'hBEEF0000_00000000, 64'h00000000_0000BEEF);
      load_case("lwu", 3'b110, 64'h3004, 64'hBEEF0000_00000000, 64'h00000000_BEEF0000);
      load_case("lh",  3'b001, 64'h3006, 64'hBEEF0000_00000000, 64'hFFFFFFFF_FFFFBEEF);
      load_case("lw",  3'b010, 64'h3004, 64'hBEEF0000_00000000, 64'hFFFFFFFF_BEEF0000);
      load_case("ld",  3'b011, 64'h3000, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
      load_case("lbu", 3'b100, 64'h3001, 64'h00000000_0000F000, 64'h00000000_000000F0);

      // misaligned LD: error response in N+1, no memory request
      issue(1'b0, 3'b011, 64'h4004, 64'h0);
      chk("ld_mis_valid", {63'h0, rsp_valid}, 64'h1);
      chk("ld_mis_err", {63'h0, rsp_err}, 64'h1);
      chk("ld_mis_mem_req", {63'h0, mem_req}, 64'h0);
      chk("ld_mis_rdata", rsp_rdata, 64'h0);
      @(negedge clk);
      chk("ld_mis_ready", {63'h0, req_ready}, 64'h1);

      // illegal store funct3
      issue(1'b1, 3'b100, 64'h5000, 64'h1);
      chk("st_ill_valid", {63'h0, rsp_valid}, 64'h1);
      chk("st_ill_err", {63'h0, rsp_err}, 64'h1);
      chk("st_ill_mem_req", {63'h0, mem_req}, 64'h0);
      @(negedge clk);

      // misaligned halfword and illegal load funct3 111
      issue(1'b0, 3'b001, 64'h5001, 64'h0);
      chk("lh_mis_err", {63'h0, rsp_err}, 64'h1);
      @(negedge clk);
      issue(1'b0, 3'b111, 64'h5000, 64'h0);
      chk("ld_ill_err", {63'h0, rsp_err}, 64'h1);
      chk("ld_ill_mem_req", {63'h0, mem_req}, 64'h0);
      @(negedge clk);

      // reset while a request is outstanding, then a stray ack
      issue(1'b0, 3'b011, 64'h6000, 64'h0);
      chk("rst_mid_mem_req_before", {63'h0, mem_req}, 64'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", {63'h0, mem_req}, 64'h0);
      chk("rst_mid_ready", {63'h0, req_ready}, 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("stray_ack_valid", {63'h0, rsp_valid}, 64'h0);
      @(negedge clk);
      chk("stray_ack_valid2", {63'h0, rsp_valid}, 64'h0);

`ifdef LSU_TIMEOUT_EN
      // never acked: error after four ACCESS cycles
      issue(1'b0, 3'b011, 64'h7000, 64'h0);
      repeat (3) @(negedge clk);
      chk("to_not_yet", {63'h0, rsp_valid}, 64'h0);
      @(negedge clk);
      chk("to_valid", {63'h0, rsp_valid}, 64'h1);
      chk("to_err", {63'h0, rsp_err}, 64'h1);
      chk("to_mem_req", {63'h0, mem_req}, 64'h0);
      chk("to_rdata", rsp_rdata, 64'h0);
      @(negedge clk);
      // ack in the fourth ACCESS cycle completes normally
      issue(1'b0, 3'b011, 64'h7000, 64'h0);
      repeat (3) @(negedge clk);
      ack_now(64'h55AA55AA_55AA55AA);
      chk("to_ack_valid", {63'h0, rsp_valid}, 64'h1);
      chk("to_ack_err", {63'h0, rsp_err}, 64'h0);
      chk("to_ack_rdata", rsp_rdata, 64'h55AA55AA_55AA55AA);
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
